// File: rtl/fetch_align_queue_if.sv
// fetch_align_queue_if: fetch packet bus, decode handshake and status between fetch, queue and decode
interface fetch_align_queue_if #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128,
    parameter int DEPTH   = 8
);
    logic                   flush;
    logic                   fetch_valid;
    logic [CL_SIZE-1:0]     fetch_line;
    logic [XLEN-1:0]        fetch_pc;
    logic                   fetch_exc;
    logic                   fetch_ready;
    logic                   stall_out;
    logic                   dec_valid;
    logic [XLEN-1:0]        dec_inst;
    logic [XLEN-1:0]        dec_pc;
    logic                   dec_exc;
    logic                   dec_ready;
    logic [$clog2(DEPTH):0] occupancy;

    modport master (
        output flush, fetch_valid, fetch_line, fetch_pc, fetch_exc, dec_ready,
        input  fetch_ready, stall_out, dec_valid, dec_inst, dec_pc, dec_exc, occupancy
    );

    modport slave (
        input  flush, fetch_valid, fetch_line, fetch_pc, fetch_exc, dec_ready,
        output fetch_ready, stall_out, dec_valid, dec_inst, dec_pc, dec_exc, occupancy
    );
endinterface

// File: rtl/fetch_align_queue.sv
// fetch_align_queue: splits 128-bit fetch lines into 32-bit slots and queues them for decode; FAQ_BYPASS_EN enables empty-queue bypass
module fetch_align_queue #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128,
    parameter int DEPTH   = 8
) (
    input logic                clk,
    input logic                rst,
    fetch_align_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic            mem_exc  [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [1:0]      start;
    logic [2:0]      n, n_wr;
    logic            push, pop, pop_mem, bypass, skip;
    logic [XLEN-1:0] first_inst, first_pc;
    logic [1:0]      slot   [4];
    logic            wr_en  [4];
    logic [XLEN-1:0] w_inst [4];
    logic [XLEN-1:0] w_pc   [4];

    assign start = bus.fetch_pc[3:2];
    assign n     = bus.fetch_exc ? 3'd1 : 3'd4 - {1'b0, start};

    // Readiness comes from registered count only, so dec_ready never reaches fetch_ready
    assign bus.fetch_ready = count <= CW'(DEPTH - 4);
    assign bus.stall_out   = !bus.fetch_ready;
    assign push            = bus.fetch_valid && bus.fetch_ready && !bus.flush;

`ifdef FAQ_BYPASS_EN
    assign bypass = (count == '0) && push;
`else
    assign bypass = 1'b0;
`endif

    assign bus.dec_valid = (count != '0) || bypass;
    assign pop           = bus.dec_valid && bus.dec_ready && !bus.flush;
    // A bypassed slot consumed in the same cycle is never written
    assign skip          = bypass && bus.dec_ready;
    assign pop_mem       = pop && !skip;
    assign n_wr          = push ? n - {2'b00, skip} : 3'd0;

    assign first_inst = bus.fetch_exc ? NOP : bus.fetch_line[{start, 5'b0} +: XLEN];
    assign first_pc   = bus.fetch_exc ? bus.fetch_pc : {bus.fetch_pc[XLEN-1:4], start, 2'b00};

    assign bus.dec_inst  = !bus.dec_valid ? '0 : bypass ? first_inst : mem_inst[head];
    assign bus.dec_pc    = !bus.dec_valid ? '0 : bypass ? first_pc : mem_pc[head];
    assign bus.dec_exc   = bus.dec_valid && (bypass ? bus.fetch_exc : mem_exc[head]);
    assign bus.occupancy = count;

    // Map write lane j to its source slot and decide whether the lane is used
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            slot[j]   = start + 2'(j) + {1'b0, skip};
            wr_en[j]  = push && ((3'(j) + {2'b00, skip}) < n);
            w_inst[j] = bus.fetch_exc ? NOP : bus.fetch_line[{slot[j], 5'b0} +: XLEN];
            w_pc[j]   = bus.fetch_exc ? bus.fetch_pc : {bus.fetch_pc[XLEN-1:4], slot[j], 2'b00};
        end
    end

    // Entry storage: lanes land at consecutive tail positions, wrapping modulo DEPTH
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (wr_en[j]) begin
                mem_inst[tail + AW'(j)] <= w_inst[j];
                mem_pc[tail + AW'(j)]   <= w_pc[j];
                mem_exc[tail + AW'(j)]  <= bus.fetch_exc;
            end
        end
    end

    // Pointers and count; flush drops everything, including the same-cycle push and pop
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_mem);
            tail  <= tail + AW'(n_wr);
            count <= count + CW'(n_wr) - CW'(pop_mem);
        end
    end
endmodule

// File: tb/tb_fetch_align_queue.sv
// tb_fetch_align_queue: scoreboard bench; driver predicts queued entries, monitor compares decode outputs
module tb_fetch_align_queue;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ent_t q[$];
    ent_t inflight[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   acc;
    logic [127:0] l1, l2;

    fetch_align_queue_if #(.XLEN(32), .CL_SIZE(128), .DEPTH(8)) bus();

    fetch_align_queue #(.XLEN(32), .CL_SIZE(128), .DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and record what an accepted packet must produce
    task automatic drive(input bit fv, input logic [127:0] line, input logic [31:0] pc,
                         input bit ex, input bit dr, input bit fl);
        @(posedge clk);
        #1;
        bus.fetch_valid = fv;
        bus.fetch_line  = line;
        bus.fetch_pc    = pc;
        bus.fetch_exc   = ex;
        bus.dec_ready   = dr;
        bus.flush       = fl;
        acc = fv && !fl && !rst && (8 - q.size() >= 4);
        if (acc) begin
            if (ex) inflight.push_back('{inst: 32'h13, pc: pc, exc: 1'b1});
            else for (int s = int'(pc[3:2]); s < 4; s++)
                inflight.push_back('{inst: line[32*s +: 32], pc: {pc[31:4], 2'(s), 2'b00}, exc: 1'b0});
        end
    endtask

    task automatic idle(input int cycles, input bit dr);
        repeat (cycles) drive(1'b0, '0, '0, 1'b0, dr, 1'b0);
    endtask

    task automatic hold(input logic [127:0] line, input logic [31:0] pc, input bit dr);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, line, pc, 1'b0, dr, 1'b0);
            if (acc) break;
        end
    endtask

    // Monitor: compare outputs against the reference queue, then apply this cycle's pop/push/flush
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                inflight.delete();
            end else begin
                chk("dec_valid", 72'(bus.dec_valid), 72'(q.size() != 0));
                chk("occupancy", 72'(bus.occupancy), 72'(q.size()));
                chk("fetch_ready", 72'(bus.fetch_ready), 72'(8 - q.size() >= 4));
                chk("stall_out", 72'(bus.stall_out), 72'(8 - q.size() < 4));
                if (q.size() != 0)
                    chk("dec_head", 72'({bus.dec_inst, bus.dec_pc, bus.dec_exc}), 72'(q[0]));
                else
                    chk("dec_idle", 72'({bus.dec_inst, bus.dec_pc, bus.dec_exc}), 72'(0));
                if (bus.flush) begin
                    q.delete();
                    inflight.delete();
                end else begin
                    if (q.size() != 0 && bus.dec_ready) void'(q.pop_front());
                    while (inflight.size() != 0) q.push_back(inflight.pop_front());
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_line  = '0;
        bus.fetch_pc    = '0;
        bus.fetch_exc   = 1'b0;
        bus.dec_ready   = 1'b0;
        bus.flush       = 1'b0;
        l1 = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        l2 = {32'h4444_0044, 32'h3333_0033, 32'h2222_0022, 32'h1111_0011};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, l1, 32'h1000, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);
        drive(1'b1, l2, 32'h2008, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(3, 1'b1);
        drive(1'b1, l1, 32'h4000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, l2, 32'h4010, 1'b0, 1'b0, 1'b0);
        drive(1'b1, l1, 32'h4020, 1'b0, 1'b0, 1'b0);
        drive(1'b1, l1, 32'h4020, 1'b0, 1'b0, 1'b0);
        hold(l1, 32'h4020, 1'b1);
        idle(12, 1'b1);
        drive(1'b1, l2, 32'h3004, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, l1, 32'h5000, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b1);
        drive(1'b1, l2, 32'h5010, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        drive(1'b1, l1, 32'h5024, 1'b0, 1'b0, 1'b0);
        hold(l2, 32'h5030, 1'b1);
        idle(12, 1'b1);
        drive(1'b1, l1, 32'h6000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, l2, 32'h6010, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = $urandom();
            pc[1:0] = 2'b00;
            drive(1'($urandom_range(0, 1)), {$urandom(), $urandom(), $urandom(), $urandom()}, pc,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        idle(12, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
